// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared constants for the multi-cycle control FSM
// Contents: state encodings IF..WB, state width, default SRAM latency,
// retire counter width.
package mc_ctrl_pkg;

   localparam int STATE_W      = 3;
   localparam int SRAM_LAT_DEF = 1;
   localparam int RETIRE_W     = 32;

   localparam logic [STATE_W-1:0] S_IF  = 3'd0;
   localparam logic [STATE_W-1:0] S_ID  = 3'd1;
   localparam logic [STATE_W-1:0] S_EXE = 3'd2;
   localparam logic [STATE_W-1:0] S_MEM = 3'd3;
   localparam logic [STATE_W-1:0] S_WB  = 3'd4;

endpackage

// File: rtl/mc_wait_cnt.sv
// rtl/mc_wait_cnt.sv - SRAM latency wait counter shared by IF and MEM
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   clr          force the count to zero (has priority over en)
//   en           advance the count by one
//   cnt          current count
//   done         count has reached SRAM_LAT-1 (data is available this cycle)
module mc_wait_cnt #(
   parameter int SRAM_LAT = 1,
   parameter int CNT_W    = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt  = cnt_q;
   assign done = (cnt_q == CNT_W'(SRAM_LAT - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle IF/ID/EXE/MEM/WB sequencer for the LoongArch datapath
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   halt_req          hold the core before the next fetch
//   dec_is_branch/load/store, dec_gr_we   decoded class flags of the current IR
//   br_taken          branch condition from the datapath, valid in EXE
//   state             current state (IF=0 ID=1 EXE=2 MEM=3 WB=4)
//   inst_sram_req, ir_we                   fetch request / IR latch
//   data_sram_req, data_sram_we, mdr_we    data access / write strobe / MDR latch
//   rf_we, pc_we, pc_sel_br                regfile write, PC write, PC source
//   inst_retire, retire_cnt                retire pulse and running count
//   busy              an instruction is in flight
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int SRAM_LAT = SRAM_LAT_DEF,
   parameter int CNT_W    = 3
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                halt_req,
   input  logic                dec_is_branch,
   input  logic                dec_is_load,
   input  logic                dec_is_store,
   input  logic                dec_gr_we,
   input  logic                br_taken,
   output logic [STATE_W-1:0]  state,
   output logic                inst_sram_req,
   output logic                ir_we,
   output logic                data_sram_req,
   output logic                data_sram_we,
   output logic                mdr_we,
   output logic                rf_we,
   output logic                pc_we,
   output logic                pc_sel_br,
   output logic                inst_retire,
   output logic [RETIRE_W-1:0] retire_cnt,
   output logic                busy
);

   logic [STATE_W-1:0]  state_q, state_d;
   logic                started_q;
   logic                br_taken_q;
   logic [RETIRE_W-1:0] retire_cnt_q;
   logic [CNT_W-1:0]    cnt;
   logic                cnt_done, cnt_clr, cnt_en, cnt_zero;
   logic                is_br, is_ld, is_st;

   // class priority when the decoder raises several flags: branch > load > store
   assign is_br    = dec_is_branch;
   assign is_ld    = dec_is_load & ~dec_is_branch;
   assign is_st    = dec_is_store & ~dec_is_branch & ~dec_is_load;
   assign cnt_zero = (cnt == '0);

   mc_wait_cnt #(
      .SRAM_LAT (SRAM_LAT),
      .CNT_W    (CNT_W)
   ) u_wait_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .cnt    (cnt),
      .done   (cnt_done)
   );

   always_comb begin
      state_d       = state_q;
      inst_sram_req = 1'b0;
      ir_we         = 1'b0;
      data_sram_req = 1'b0;
      data_sram_we  = 1'b0;
      mdr_we        = 1'b0;
      rf_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel_br     = 1'b0;
      inst_retire   = 1'b0;
      cnt_en        = 1'b0;
      busy          = 1'b1;
      case (state_q)
         S_IF: begin
            // a nonzero count means the fetch is already out, so halt no longer matters
            if (cnt_zero && (!started_q || halt_req)) begin
               busy = 1'b0;
            end else begin
               inst_sram_req = cnt_zero;
               if (cnt_done) begin
                  ir_we   = 1'b1;
                  state_d = S_ID;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         S_ID: state_d = S_EXE;
         S_EXE: begin
            if (is_br && !dec_gr_we) begin
               pc_we       = 1'b1;
               pc_sel_br   = br_taken;
               inst_retire = 1'b1;
               state_d     = S_IF;
            end else if (is_br) begin
               state_d = S_WB;
            end else if (is_ld || is_st) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (is_ld) begin
               data_sram_req = cnt_zero;
               if (cnt_done) begin
                  mdr_we  = 1'b1;
                  state_d = S_WB;
               end else begin
                  cnt_en = 1'b1;
               end
            end else begin
               // store completes in a single MEM cycle and retires there
               data_sram_req = 1'b1;
               data_sram_we  = 1'b1;
               pc_we         = 1'b1;
               inst_retire   = 1'b1;
               state_d       = S_IF;
            end
         end
         S_WB: begin
            rf_we       = dec_gr_we;
            pc_we       = 1'b1;
            pc_sel_br   = is_br & br_taken_q;
            inst_retire = 1'b1;
            state_d     = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   // the counter starts from zero on every entry into a waiting state
   assign cnt_clr = (state_d != state_q) && ((state_d == S_IF) || (state_d == S_MEM));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IF;
         started_q    <= 1'b0;
         br_taken_q   <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
         if (state_q == S_EXE) begin
            br_taken_q <= br_taken;
         end
         if (inst_retire) begin
            retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
         end
      end
   end

   assign state      = state_q;
   assign retire_cnt = retire_cnt_q;

endmodule
